csi2tx_ldl_pkt_tracker: RTL and testbench



---
 rtl/csi2tx_ldl_pkg.sv | 39 +++
 rtl/csi2tx_ldl_hdr_ecc.sv | 18 +
 rtl/csi2tx_ldl_pkt_tracker.sv | 173 +++++++++++++++++
 tb/tb_csi2tx_ldl_pkt_tracker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2tx_ldl_pkg.sv
// Shared definitions for the CSI-2 TX lane-distribution packet tracker.
//   - packet header field offsets and packet sizing constants
//   - tracker FSM state encoding (also driven out on the debug state port)
//   - CSI-2 header ECC parity masks, used only when CSI2TX_LDL_HDR_ECC_CHK_EN
//     is defined
package csi2tx_ldl_pkg;

    // Data types 0x00..0x0F are short packets (sync / generic short).
    localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

    localparam int PH_BYTES  = 4;   // packet header: DI, WC lo, WC hi, ECC
    localparam int CRC_BYTES = 2;   // long-packet footer

    // Header word layout as it sits in the low 32 bits of the delayed word.
    localparam int DI_LSB  = 0;
    localparam int DI_MSB  = 7;
    localparam int WC_LSB  = 8;
    localparam int WC_MSB  = 23;
    localparam int ECC_LSB = 24;
    localparam int ECC_MSB = 29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } trk_state_e;

    // Parity bit i of the header ECC is the XOR of the header bits selected
    // by ECC_MASK[i]; entry 0 is P0.
    localparam logic [5:0][23:0] ECC_MASK = {
        24'hEFFC00,   // P5
        24'hDF03F0,   // P4
        24'hB8E38E,   // P3
        24'h749A6D,   // P2
        24'hF2555B,   // P1
        24'hF12CB7    // P0
    };

endpackage

// File: rtl/csi2tx_ldl_hdr_ecc.sv
// Combinational CSI-2 packet-header ECC generator.
//   hdr_data : 24 header bits (DI + WC)
//   ecc      : 6-bit Hamming ECC over hdr_data (bits 7:6 of the ECC byte are 0)
module csi2tx_ldl_hdr_ecc
    import csi2tx_ldl_pkg::*;
(
    input  logic [23:0] hdr_data,
    output logic [5:0]  ecc
);

    always_comb begin
        ecc = '0;
        for (int i = 0; i < 6; i++) begin
            ecc[i] = ^(hdr_data & ECC_MASK[i]);
        end
    end

endmodule

// File: rtl/csi2tx_ldl_pkt_tracker.sv
// Packet-level bookkeeping in front of the five-lane distribution FSM.
// Keeps the byte-FIFO read-data delay line, classifies the packet from its
// header, and tracks FIFO words read and lane bytes still to send.
//
// Ports
//   txbyteclkhs / txbyteclkhs_rst_n : HS byte clock, async active-low reset
//   forcetxstopmode   : synchronous abort, returns the tracker to IDLE
//   fifo_rd_en        : FWFT FIFO read strobe from the distributor
//   fifo_rd_data      : FIFO head word
//   header_info       : strobe, header word is in fifo_rd_data_d[31:0]
//   txreadyhs0/txrequesths0 : lane-0 handshake; a beat is both high
//   tx_done           : distributor is in its stop state
//   fifo_rd_data_d/d1/d2 : delayed FIFO words for the lane data mux
//   short_packet, validated_word_cnt, eop_rd, eop_wr : distributor controls
//   hdr_ecc_err       : header ECC mismatch (0 unless the feature is built)
//   dbg_state         : tracker FSM state
//
// Handshake: a lane beat is accepted on a rising clock edge where
// txrequesths0 and txreadyhs0 are both 1; a FIFO word is consumed on a
// rising edge where fifo_rd_en is 1. Neither side waits on the other here.
//
// Optional: define CSI2TX_LDL_HDR_ECC_CHK_EN to check the header ECC.
module csi2tx_ldl_pkt_tracker
    import csi2tx_ldl_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int LANE_BYTES = 5,
    parameter int CNT_W      = 17
) (
    input  logic              txbyteclkhs,
    input  logic              txbyteclkhs_rst_n,
    input  logic              forcetxstopmode,
    input  logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              header_info,
    input  logic              txreadyhs0,
    input  logic              txrequesths0,
    input  logic              tx_done,
    output logic [DATA_W-1:0] fifo_rd_data_d,
    output logic [DATA_W-1:0] fifo_rd_data_d1,
    output logic [DATA_W-1:0] fifo_rd_data_d2,
    output logic              short_packet,
    output logic [CNT_W-1:0]  validated_word_cnt,
    output logic              eop_rd,
    output logic              eop_wr,
    output logic              hdr_ecc_err,
    output trk_state_e        dbg_state
);

    localparam int BPW = DATA_W / 8;   // bytes per FIFO word

    trk_state_e       state, state_nxt;
    logic [CNT_W-1:0] rem_bytes;
    logic [CNT_W-1:0] words_need;
    logic [CNT_W-1:0] words_rd;
    logic             tx_done_q;

    logic             beat;
    logic             hdr_accept;
    logic [7:0]       hdr_di;
    logic [15:0]      hdr_wc;
    logic             hdr_short;
    logic [CNT_W-1:0] hdr_tot;
    logic [CNT_W-1:0] rem_after;
    logic             last_beat;

    assign beat       = txreadyhs0 & txrequesths0;
    assign hdr_accept = (state == ST_IDLE) & header_info & ~forcetxstopmode;

    assign hdr_di    = fifo_rd_data_d[DI_MSB:DI_LSB];
    assign hdr_wc    = fifo_rd_data_d[WC_MSB:WC_LSB];
    assign hdr_short = (hdr_di[5:0] <= SHORT_DT_MAX);
    assign hdr_tot   = hdr_short ? CNT_W'(PH_BYTES)
                                 : CNT_W'(hdr_wc) + CNT_W'(PH_BYTES + CRC_BYTES);

    // Remaining bytes after one beat, floored at zero.
    assign rem_after = (rem_bytes > CNT_W'(LANE_BYTES)) ? rem_bytes - CNT_W'(LANE_BYTES)
                                                        : '0;
    assign last_beat = beat & (rem_bytes <= CNT_W'(LANE_BYTES));

    // Read-data delay line; survives forcetxstopmode on purpose.
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            fifo_rd_data_d  <= '0;
            fifo_rd_data_d1 <= '0;
            fifo_rd_data_d2 <= '0;
        end else if (fifo_rd_en) begin
            fifo_rd_data_d  <= fifo_rd_data;
            fifo_rd_data_d1 <= fifo_rd_data_d;
            fifo_rd_data_d2 <= fifo_rd_data_d1;
        end
    end

    // FSM state register
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            state     <= ST_IDLE;
            tx_done_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_done_q <= tx_done;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (header_info)               state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (last_beat)                 state_nxt = ST_DONE;
            ST_DONE:   if (tx_done_q && !tx_done)     state_nxt = ST_IDLE;
            default:                                  state_nxt = ST_IDLE;
        endcase
        if (forcetxstopmode) state_nxt = ST_IDLE;
    end

    // Packet counters
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            rem_bytes    <= '0;
            words_need   <= '0;
            words_rd     <= '0;
            short_packet <= 1'b0;
        end else if (forcetxstopmode) begin
            rem_bytes    <= '0;
            words_rd     <= '0;
            short_packet <= 1'b0;
        end else if (hdr_accept) begin
            rem_bytes    <= hdr_tot;
            words_need   <= (hdr_tot + CNT_W'(BPW - 1)) / CNT_W'(BPW);
            // The header word itself was read before header_info fired.
            words_rd     <= CNT_W'(1);
            short_packet <= hdr_short;
        end else if (state == ST_ACTIVE) begin
            if (fifo_rd_en && (words_rd < words_need)) words_rd <= words_rd + 1'b1;
            if (beat) rem_bytes <= rem_after;
        end
    end

    // Look-ahead count lets the distributor size its next request on the
    // same edge that consumes the current beat.
    always_comb begin
        validated_word_cnt = rem_bytes;
        if (state == ST_IDLE)                 validated_word_cnt = '0;
        else if (state == ST_ACTIVE && beat)  validated_word_cnt = rem_after;
    end

    assign eop_rd = ((state == ST_ACTIVE) && (words_rd >= words_need)) || (state == ST_DONE);
    assign eop_wr = (state == ST_ACTIVE) & last_beat;
    assign dbg_state = state;

`ifdef CSI2TX_LDL_HDR_ECC_CHK_EN
    logic [5:0] ecc_calc;

    csi2tx_ldl_hdr_ecc u_hdr_ecc (
        .hdr_data (fifo_rd_data_d[23:0]),
        .ecc      (ecc_calc)
    );

    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            hdr_ecc_err <= 1'b0;
        end else if (forcetxstopmode) begin
            hdr_ecc_err <= 1'b0;
        end else if (hdr_accept) begin
            hdr_ecc_err <= (ecc_calc != fifo_rd_data_d[ECC_MSB:ECC_LSB]);
        end
    end
`else
    assign hdr_ecc_err = 1'b0;
`endif

endmodule

// File: tb/tb_csi2tx_ldl_pkt_tracker.sv
module tb_csi2tx_ldl_pkt_tracker;
    import csi2tx_ldl_pkg::*;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 17;

    logic              txbyteclkhs = 1'b0;
    logic              txbyteclkhs_rst_n;
    logic              forcetxstopmode;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              header_info;
    logic              txreadyhs0;
    logic              txrequesths0;
    logic              tx_done;
    logic [DATA_W-1:0] fifo_rd_data_d;
    logic [DATA_W-1:0] fifo_rd_data_d1;
    logic [DATA_W-1:0] fifo_rd_data_d2;
    logic              short_packet;
    logic [CNT_W-1:0]  validated_word_cnt;
    logic              eop_rd;
    logic              eop_wr;
    logic              hdr_ecc_err;
    trk_state_e        dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 txbyteclkhs = ~txbyteclkhs;

    csi2tx_ldl_pkt_tracker #(.DATA_W(DATA_W), .LANE_BYTES(5), .CNT_W(CNT_W)) dut (
        .txbyteclkhs        (txbyteclkhs),
        .txbyteclkhs_rst_n  (txbyteclkhs_rst_n),
        .forcetxstopmode    (forcetxstopmode),
        .fifo_rd_en         (fifo_rd_en),
        .fifo_rd_data       (fifo_rd_data),
        .header_info        (header_info),
        .txreadyhs0         (txreadyhs0),
        .txrequesths0       (txrequesths0),
        .tx_done            (tx_done),
        .fifo_rd_data_d     (fifo_rd_data_d),
        .fifo_rd_data_d1    (fifo_rd_data_d1),
        .fifo_rd_data_d2    (fifo_rd_data_d2),
        .short_packet       (short_packet),
        .validated_word_cnt (validated_word_cnt),
        .eop_rd             (eop_rd),
        .eop_wr             (eop_wr),
        .hdr_ecc_err        (hdr_ecc_err),
        .dbg_state          (dbg_state)
    );

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; checks follow a
    // further #1 so combinational outputs have settled.
    task automatic tick();
        @(posedge txbyteclkhs);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Read the header word out of the FIFO, then strobe header_info.
    task automatic load_hdr(input logic [31:0] hdr);
        fifo_rd_en   = 1'b1;
        fifo_rd_data = {32'hCAFE_F00D, hdr};
        tick();
        fifo_rd_en   = 1'b0;
        fifo_rd_data = '0;
        header_info  = 1'b1;
        tick();
        header_info  = 1'b0;
        settle();
    endtask

    task automatic abort();
        forcetxstopmode = 1'b1;
        tick();
        forcetxstopmode = 1'b0;
        settle();
    endtask

    task automatic set_beat(input logic on);
        txrequesths0 = on;
        txreadyhs0   = on;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        txbyteclkhs_rst_n = 1'b0;
        forcetxstopmode   = 1'b0;
        fifo_rd_en        = 1'b0;
        fifo_rd_data      = '0;
        header_info       = 1'b0;
        txreadyhs0        = 1'b0;
        txrequesths0      = 1'b0;
        tx_done           = 1'b0;

        repeat (2) @(posedge txbyteclkhs);
        #1;
        check("rst_d",     fifo_rd_data_d, 64'h0);
        check("rst_d1",    fifo_rd_data_d1, 64'h0);
        check("rst_d2",    fifo_rd_data_d2, 64'h0);
        check("rst_short", short_packet, 1'b0);
        check("rst_vwc",   validated_word_cnt, 0);
        check("rst_eoprd", eop_rd, 1'b0);
        check("rst_eopwr", eop_wr, 1'b0);
        check("rst_ecc",   hdr_ecc_err, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        txbyteclkhs_rst_n = 1'b1;
        tick();

        // ---- pipeline: A, B, C then idle ----
        fifo_rd_en = 1'b1;
        fifo_rd_data = 64'hAAAA_0000_0000_00A1; tick();
        fifo_rd_data = 64'hBBBB_0000_0000_00B2; tick();
        fifo_rd_data = 64'hCCCC_0000_0000_00C3; tick();
        fifo_rd_en = 1'b0;
        fifo_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        settle();
        check("pipe_d",  fifo_rd_data_d,  64'hCCCC_0000_0000_00C3);
        check("pipe_d1", fifo_rd_data_d1, 64'hBBBB_0000_0000_00B2);
        check("pipe_d2", fifo_rd_data_d2, 64'hAAAA_0000_0000_00A1);
        repeat (3) tick();
        check("pipe_hold_d",  fifo_rd_data_d,  64'hCCCC_0000_0000_00C3);
        check("pipe_hold_d2", fifo_rd_data_d2, 64'hAAAA_0000_0000_00A1);
        check("pipe_idle",    dbg_state, ST_IDLE);

        // ---- long packet DT=0x2A WC=10: tot 16, 2 words ----
        load_hdr(32'h2900_0A2A);
        check("long_state", dbg_state, ST_ACTIVE);
        check("long_short", short_packet, 1'b0);
        check("long_vwc0",  validated_word_cnt, 16);
        check("long_eoprd0", eop_rd, 1'b0);
        txrequesths0 = 1'b1; txreadyhs0 = 1'b0; settle();
        check("long_noready_vwc", validated_word_cnt, 16);
        tick();
        txreadyhs0 = 1'b1; settle();
        check("long_b1_vwc", validated_word_cnt, 11);
        check("long_b1_eopwr", eop_wr, 1'b0);
        tick(); settle();
        check("long_b2_vwc", validated_word_cnt, 6);
        tick(); settle();
        check("long_b3_vwc", validated_word_cnt, 1);
        check("long_b3_eopwr", eop_wr, 1'b0);
        tick();
        set_beat(1'b0); fifo_rd_en = 1'b1; settle();
        check("long_rem1", validated_word_cnt, 1);
        check("long_eoprd_pre", eop_rd, 1'b0);
        tick();
        fifo_rd_en = 1'b0; settle();
        check("long_eoprd", eop_rd, 1'b1);
        check("long_active", dbg_state, ST_ACTIVE);
        set_beat(1'b1); settle();
        check("long_b4_vwc", validated_word_cnt, 0);
        check("long_b4_eopwr", eop_wr, 1'b1);
        tick();
        settle();
        check("long_done", dbg_state, ST_DONE);
        check("done_eopwr", eop_wr, 1'b0);
        check("done_vwc", validated_word_cnt, 0);
        set_beat(1'b0);
        check("done_eoprd", eop_rd, 1'b1);
        header_info = 1'b1; tick(); header_info = 1'b0; settle();
        check("done_hdr_ignored", dbg_state, ST_DONE);
        tx_done = 1'b1; tick(); settle();
        check("done_txdone_hi", dbg_state, ST_DONE);
        tx_done = 1'b0; tick(); settle();
        check("txdone_fall_idle", dbg_state, ST_IDLE);
        check("idle_vwc", validated_word_cnt, 0);
        check("idle_eoprd", eop_rd, 1'b0);

        // ---- short packet DT=0x00 ----
        load_hdr(32'h0012_3400);
        check("short_flag", short_packet, 1'b1);
        check("short_vwc", validated_word_cnt, 4);
        check("short_eoprd", eop_rd, 1'b1);
        set_beat(1'b1); settle();
        check("short_beat_vwc", validated_word_cnt, 0);
        check("short_eopwr", eop_wr, 1'b1);
        tick(); set_beat(1'b0); settle();
        check("short_done", dbg_state, ST_DONE);
        abort();

        // ---- DT boundaries: 0x0F short, 0x10 long ----
        load_hdr(32'h0000_400F);
        check("dt0f_short", short_packet, 1'b1);
        check("dt0f_vwc", validated_word_cnt, 4);
        abort();
        check("abort_short_clr", short_packet, 1'b0);
        load_hdr(32'h0000_0010);
        check("dt10_short", short_packet, 1'b0);
        check("dt10_vwc", validated_word_cnt, 6);
        check("dt10_eoprd", eop_rd, 1'b1);
        abort();

        // ---- forcetxstopmode with 30 bytes pending ----
        load_hdr(32'h0000_182A);
        check("force_pre_vwc", validated_word_cnt, 30);
        forcetxstopmode = 1'b1; tick(); settle();
        check("force_idle", dbg_state, ST_IDLE);
        check("force_vwc", validated_word_cnt, 0);
        check("force_short", short_packet, 1'b0);
        check("force_eoprd", eop_rd, 1'b0);
        check("force_pipe_kept", fifo_rd_data_d, 64'hCAFE_F00D_0000_182A);
        header_info = 1'b1; tick(); settle();
        check("force_hdr_ignored", dbg_state, ST_IDLE);
        forcetxstopmode = 1'b0; tick(); header_info = 1'b0; settle();
        check("reload_state", dbg_state, ST_ACTIVE);
        check("reload_vwc", validated_word_cnt, 30);
        check("reload_eoprd", eop_rd, 1'b0);
        abort();

        // ---- maximum word count ----
        load_hdr(32'h00FF_FF2A);
        check("max_vwc", validated_word_cnt, 17'h10005);
        check("max_eoprd0", eop_rd, 1'b0);
        fifo_rd_en = 1'b1;
        repeat (8191) tick();
        fifo_rd_en = 1'b0; settle();
        check("max_eoprd_8192", eop_rd, 1'b0);
        fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0; settle();
        check("max_eoprd_8193", eop_rd, 1'b1);
        fifo_rd_en = 1'b1; repeat (3) tick(); fifo_rd_en = 1'b0; settle();
        check("max_eoprd_sat", eop_rd, 1'b1);
        set_beat(1'b1); settle();
        check("max_beat_vwc", validated_word_cnt, 17'h10000);
        tick(); set_beat(1'b0); settle();
        check("max_after_beat", validated_word_cnt, 17'h10000);
        abort();

        // ---- header ECC ----
`ifdef CSI2TX_LDL_HDR_ECC_CHK_EN
        load_hdr(32'h2900_0A2A);
        check("ecc_good", hdr_ecc_err, 1'b0);
        abort();
        load_hdr(32'h2800_0A2A);
        check("ecc_bad", hdr_ecc_err, 1'b1);
        check("ecc_flow", validated_word_cnt, 16);
        abort();
        check("ecc_clr_force", hdr_ecc_err, 1'b0);
`else
        load_hdr(32'h2800_0A2A);
        check("ecc_off", hdr_ecc_err, 1'b0);
        abort();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
